// File: rtl/spi_flash_reader.sv
// spi_flash_reader: fetches one byte per request from an SPI NOR flash
// using a READ command in SPI mode 0, and returns it with a one-cycle strobe.
module spi_flash_reader #(
    parameter int         SCK_HALF_PERIOD = 2,
    parameter int         CS_HIGH_CYCLES  = 4,
    parameter logic [7:0] READ_CMD        = 8'h03
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flash_read_req,
    input  logic [23:0] flash_addr_read,
    output logic        flash_read_en_out,
    output logic [7:0]  flash_byte_out,
    output logic        flash_cs_n,
    output logic        flash_sck,
    output logic        flash_mosi,
    input  logic        flash_miso
);

    localparam int HW = (SCK_HALF_PERIOD > 1) ? $clog2(SCK_HALF_PERIOD) : 1;
    localparam int GW = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
    localparam logic [HW-1:0] H_LAST   = HW'(SCK_HALF_PERIOD - 1);
    localparam logic [GW-1:0] G_LAST   = GW'(CS_HIGH_CYCLES - 1);
    localparam logic [5:0]    BIT_LAST = 6'd39;
    localparam logic [5:0]    RX_FIRST = 6'd32;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t          state;
    logic [HW-1:0]   half_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [5:0]      bit_cnt;
    logic [31:0]     tx_sh;
    logic [7:0]      rx_sh;

    // Transaction sequencer: every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            half_cnt          <= '0;
            gap_cnt           <= '0;
            bit_cnt           <= '0;
            tx_sh             <= '0;
            rx_sh             <= '0;
            flash_cs_n        <= 1'b1;
            flash_sck         <= 1'b0;
            flash_mosi        <= 1'b0;
            flash_read_en_out <= 1'b0;
            flash_byte_out    <= '0;
        end else begin
            flash_read_en_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (flash_read_req) begin
                        tx_sh      <= {READ_CMD, flash_addr_read};
                        flash_mosi <= READ_CMD[7];
                        flash_cs_n <= 1'b0;
                        flash_sck  <= 1'b0;
                        half_cnt   <= '0;
                        bit_cnt    <= '0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (half_cnt != H_LAST) begin
                        half_cnt <= half_cnt + 1'b1;
                    end else begin
                        half_cnt <= '0;
                        if (!flash_sck) begin
                            // Rising SCK: the flash has had a full low phase to drive MISO.
                            flash_sck <= 1'b1;
                            if (bit_cnt >= RX_FIRST)
                                rx_sh <= {rx_sh[6:0], flash_miso};
                        end else begin
                            flash_sck <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                flash_cs_n        <= 1'b1;
                                flash_mosi        <= 1'b0;
                                flash_byte_out    <= rx_sh;
                                flash_read_en_out <= 1'b1;
                                gap_cnt           <= '0;
                                state             <= GAP;
                            end else begin
                                // Zeros shift in behind the address, so MOSI idles low
                                // through the data phase with no extra muxing.
                                bit_cnt    <= bit_cnt + 1'b1;
                                tx_sh      <= {tx_sh[30:0], 1'b0};
                                flash_mosi <= tx_sh[30];
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == G_LAST)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: directed bench for two reader instances (H=2 and H=1),
// each driven by a small SPI flash model that also watches the bus protocol.
module tb_spi_flash_reader;

    localparam int CSH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req;
    logic [23:0] addr [2];
    logic [1:0] en, cs_n, sck, mosi;
    wire  [1:0] miso;
    logic [7:0] byte_o [2];
    logic [7:0] mdata [2];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // Cycle index: stable between posedges.
    always @(posedge clk) cyc <= cyc + 1;

    spi_flash_reader #(.SCK_HALF_PERIOD(2), .CS_HIGH_CYCLES(CSH), .READ_CMD(8'h03)) u_h2 (
        .clk(clk), .reset_n(reset_n), .flash_read_req(req[0]), .flash_addr_read(addr[0]),
        .flash_read_en_out(en[0]), .flash_byte_out(byte_o[0]), .flash_cs_n(cs_n[0]),
        .flash_sck(sck[0]), .flash_mosi(mosi[0]), .flash_miso(miso[0]));

    spi_flash_reader #(.SCK_HALF_PERIOD(1), .CS_HIGH_CYCLES(CSH), .READ_CMD(8'h03)) u_h1 (
        .clk(clk), .reset_n(reset_n), .flash_read_req(req[1]), .flash_addr_read(addr[1]),
        .flash_read_en_out(en[1]), .flash_byte_out(byte_o[1]), .flash_cs_n(cs_n[1]),
        .flash_sck(sck[1]), .flash_mosi(mosi[1]), .flash_miso(miso[1]));

    // Flash model plus protocol watcher, sampled mid-cycle when the bus is stable.
    for (genvar g = 0; g < 2; g++) begin : mdl
        localparam int H = (g == 0) ? 2 : 1;
        logic        m = 1'b0;
        logic        psck = 1'b0, pmosi = 1'b0, pcs = 1'b1;
        int          cnt = 0, rises = 0, strobes = 0, viol = 0, run = 0, hi_run = 0;
        logic [31:0] word = '0;
        assign miso[g] = m;

        always @(negedge clk) begin
            if (cs_n[g]) begin
                hi_run++;
                run = 0;
            end else if (pcs) begin
                if (hi_run < CSH) viol++;
                hi_run = 0; cnt = 0; rises = 0; word = '0; run = 0;
            end else begin
                if (sck[g] == psck) begin
                    run++;
                    if (run >= H) viol++;
                end else run = 0;
                if (sck[g] && !psck) begin
                    rises++;
                    if (cnt < 32) word = {word[30:0], mosi[g]};
                    cnt++;
                end
                if (!sck[g] && psck && cnt >= 32 && cnt < 40) m = mdata[g][39 - cnt];
            end
            if (psck && sck[g] && mosi[g] !== pmosi) viol++;
            if (cs_n[g] !== pcs && sck[g]) viol++;
            if (!cs_n[g] && rises >= 40 && !sck[g]) viol++;
            if (en[g]) strobes++;
            psck = sck[g]; pmosi = mosi[g]; pcs = cs_n[g];
        end
    end

    function automatic logic [31:0] word_of(int g);
        return (g == 0) ? mdl[0].word : mdl[1].word;
    endfunction
    function automatic int rises_of(int g);
        return (g == 0) ? mdl[0].rises : mdl[1].rises;
    endfunction
    function automatic int strobes_of(int g);
        return (g == 0) ? mdl[0].strobes : mdl[1].strobes;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int g, logic [23:0] a);
        req[g]  = 1'b1;
        addr[g] = a;
        step();
        req[g]  = 1'b0;
    endtask

    task automatic wait_strobe(int g, output int sc);
        sc = -1;
        for (int i = 0; i < 400; i++) begin
            if (en[g]) begin
                sc = cyc;
                break;
            end
            step();
        end
        if (sc < 0) check("strobe_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got running exp finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, sc, s0;
        reset_n = 1'b0; req = '0;
        addr[0] = '0; addr[1] = '0; mdata[0] = '0; mdata[1] = '0;
        repeat (3) step();
        check("rst_cs",   cs_n[0],   1'b1);
        check("rst_sck",  sck[0],    1'b0);
        check("rst_mosi", mosi[0],   1'b0);
        check("rst_en",   en[0],     1'b0);
        check("rst_byte", byte_o[0], 8'h00);
        check("rst_cs1",  cs_n[1],   1'b1);
        reset_n = 1'b1;
        repeat (2) step();

        // Single read, H=2
        mdata[0] = 8'hA5; r = cyc;
        issue(0, 24'h123456);
        check("t0_cs",   cs_n[0], 1'b0);
        check("t0_sck",  sck[0],  1'b0);
        check("t0_mosi", mosi[0], 1'b0);
        wait_strobe(0, sc);
        check("lat_h2",   sc - r,      32'd161);
        check("byte_h2",  byte_o[0],   8'hA5);
        check("cs_done",  cs_n[0],     1'b1);
        check("word_h2",  word_of(0),  32'h03123456);
        check("rises_h2", rises_of(0), 32'd40);
        step();
        check("en_once", en[0], 1'b0);
        repeat (5) step();
        check("byte_hold", byte_o[0], 8'hA5);

        // Minimum divider, H=1, top address
        mdata[1] = 8'h3C; r = cyc;
        issue(1, 24'hFFFFFF);
        wait_strobe(1, sc);
        check("lat_h1",   sc - r,      32'd81);
        check("byte_h1",  byte_o[1],   8'h3C);
        check("word_h1",  word_of(1),  32'h03FFFFFF);
        check("rises_h1", rises_of(1), 32'd40);

        // Request while busy: second req dropped
        repeat (6) step();
        mdata[0] = 8'h77; r = cyc;
        issue(0, 24'h0000AA);
        repeat (19) step();
        issue(0, 24'hABCDEF);
        wait_strobe(0, sc);
        check("lat_busy",  sc - r,     32'd161);
        check("word_busy", word_of(0), 32'h030000AA);
        check("byte_busy", byte_o[0],  8'h77);

        // Back-to-back, next req exactly CSH cycles after the strobe
        repeat (CSH) step();
        mdata[0] = 8'h11; r = cyc;
        check("cs_hi_gap", cs_n[0], 1'b1);
        issue(0, 24'h000000);
        check("cs_fall_next", cs_n[0], 1'b0);
        check("strobes_busy", strobes_of(0), 32'd2);
        wait_strobe(0, sc);
        check("lat_b2b0",  sc - r,     32'd161);
        check("byte_b2b0", byte_o[0],  8'h11);
        check("word_b2b0", word_of(0), 32'h03000000);
        repeat (CSH) step();
        mdata[0] = 8'h22;
        issue(0, 24'h000001);
        wait_strobe(0, sc);
        check("byte_b2b1", byte_o[0],  8'h22);
        check("word_b2b1", word_of(0), 32'h03000001);

        // Reset during address bit 10 (SCK high at that point)
        repeat (4) step();
        mdata[0] = 8'h99; r = cyc;
        issue(0, 24'h654321);
        repeat (86) step();
        check("mid_sck_hi", sck[0], 1'b1);
        s0 = strobes_of(0);
        reset_n = 1'b0;
        #1;
        check("mid_cs",   cs_n[0],   1'b1);
        check("mid_sck",  sck[0],    1'b0);
        check("mid_mosi", mosi[0],   1'b0);
        check("mid_en",   en[0],     1'b0);
        check("mid_byte", byte_o[0], 8'h00);
        repeat (6) step();
        reset_n = 1'b1;
        step();
        mdata[0] = 8'h5A; r = cyc;
        issue(0, 24'h000100);
        wait_strobe(0, sc);
        check("lat_post",  sc - r,     32'd161);
        check("byte_post", byte_o[0],  8'h5A);
        check("word_post", word_of(0), 32'h03000100);
        step();
        check("no_abort_strobe", strobes_of(0), s0 + 1);
        check("proto", mdl[0].viol + mdl[1].viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
